sram_march_bist: RTL and testbench
==================================

# sram_march_bist

March C- built-in self-test controller that acts as the initiator on the bit-serial SRAM port of the 16x8 single-port array. On a start pulse it takes ownership of the array's we_n/addr/din inputs and drives all 128 bit cells through the six March C- elements. It checks the array's registered dout against the expected value and reports pass/fail, the first failing location, and an error count. It sits between the array and the system test/CSR logic, and holds the SRAM port idle when not running.

## Interface
- ADDR_W, 7, SRAM bit-address width; N = 2**ADDR_W cells (addr[6:3] row, addr[2:0] col)
- CNT_W, 8, error counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low (same net as the array's reset)
- start  in  1  single-cycle request; honoured only when busy=0
- busy  out  1  high from the cycle after an accepted start until done rises
- done  out  1  level; high from test completion until the next accepted start or reset
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  CNT_W  number of miscompares, saturating at all-ones
- fail_addr  out  ADDR_W  address of the first miscompare
- fail_elem  out  3  March element (0..5) of the first miscompare
- fail_exp  out  1  expected bit at the first miscompare
- sram_we_n  out  1  to array we_n, active-low write
- sram_addr  out  ADDR_W  to array addr
- sram_din  out  1  to array din
- sram_dout  in  1  from array dout (registered, 1-cycle read latency)

## Operation
- States: IDLE, RUN, DRAIN, DONE. Internal state: elem[2:0], addr counter, phase (READ/WRITE), check pipeline (chk_v, chk_exp, chk_addr, chk_elem).
- Reset value: state IDLE. All outputs 0, except sram_we_n=1.
- IDLE/DONE plus start=1: clear err_count and the fail_* outputs, set elem=0, set addr=0, go to RUN. done drops and busy rises on the next cycle.
- March C- sequence (u = addr 0 up to N-1, d = addr N-1 down to 0):
  - elem 0: u(w0)
  - elem 1: u(r0,w1)
  - elem 2: u(r1,w0)
  - elem 3: d(r0,w1)
  - elem 4: d(r1,w0)
  - elem 5: u(r0)
- Write-only cell: one cycle with sram_we_n=0, sram_addr=A, sram_din=value.
- Read-write cell: READ cycle (sram_we_n=1, sram_addr=A, sram_din=0), then WRITE cycle at the same A.
- Read-only cell: one READ cycle.
- Every READ cycle loads the check pipeline with chk_v=1, the expected bit, A and elem. In the following cycle sram_dout is compared with chk_exp.
- On a mismatch, err_count increments (saturating). If it is the first mismatch, capture chk_addr into fail_addr, chk_elem into fail_elem and chk_exp into fail_exp.
- The array returns pre-write contents for a read issued in the cycle before a same-address write. No bypass is needed.
- After elem 5 finishes at addr N-1, enter DRAIN for one cycle, with the port idle and the final compare taking place. Then go to DONE.
- start while busy: ignored.
- rst_n low in any state: return to IDLE with all outputs at reset values. The array contents are also cleared by the shared reset. A restart after reset is a full, fresh test.
- Port idle (IDLE/DRAIN/DONE): sram_we_n=1, sram_addr=0, sram_din=0.

## Timing
- Start accepted at edge E0. The first SRAM op is driven in cycle 1, after E0.
- Op cycles: elem0 N, elems 1-4 2N each, elem5 N, giving 10N total. N=128 gives cycles 1..1280.
- DRAIN is cycle 1281. done=1 and busy=0 from cycle 1282.
- Compare for the read issued in cycle k happens at the end of cycle k+1. err_count/fail_* update in cycle k+2.
- Element boundaries add no idle cycles. In up elements addr wraps from N-1 to 0 at the next element; in down elements it runs from N-1 to 0.

## Test plan
- Fault-free array model, start pulse: done rises exactly 1282 cycles after the start edge; pass=1, err_count=0; the first 128 ops are writes of 0 to addr 0..127; cycle 129 is a read of addr 0.
- Cell 0x2A stuck-at-1: pass=0, fail_addr=0x2A, fail_elem=1, fail_exp=0, err_count=3 (failures in elems 1, 3, 5).
- Cell 0x05 stuck-at-0: pass=0, fail_addr=0x05, fail_elem=2, fail_exp=1, err_count=2.
- Address trace check in elem 3: reads occur at addresses 127, 126, ... 0, each followed by a write of 1 to the same address; sram_we_n is never low in a READ cycle.
- start pulsed at cycle 500 of a run: ignored, completion still at 1282; start in DONE with a fault-free model clears err_count and the fail_* outputs and reruns.
- rst_n low for 1 cycle at cycle 700, then start: all outputs at reset values (sram_we_n=1) the cycle after reset; the rerun passes with done at +1282.

Source files
------------

// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- BIST initiator for the 16x8 bit-serial SRAM array
module sram_march_bist #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              fail_exp,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_din,
    input  logic              sram_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic PH_READ  = 1'b0;
    localparam logic PH_WRITE = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr;
    logic              phase;

    logic              chk_v;
    logic              chk_exp;
    logic [ADDR_W-1:0] chk_addr;
    logic [2:0]        chk_elem;

    logic [CNT_W-1:0]  err_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;
    logic              fail_exp_q;

    // Element decode: elem 0 is write-only, elem 5 read-only, elems 3/4 run downwards.
    logic       run;
    logic       elem_has_read;
    logic       elem_has_write;
    logic       elem_down;
    logic       read_exp;
    logic       write_val;
    logic       cycle_is_read;
    logic       cycle_is_write;
    logic       last_addr;
    logic [2:0] next_elem;
    logic       next_down;
    logic       miscompare;

    always_comb begin
        run            = (state == S_RUN);
        elem_has_read  = (elem != 3'd0);
        elem_has_write = (elem != 3'd5);
        elem_down      = (elem == 3'd3) || (elem == 3'd4);
        read_exp       = (elem == 3'd2) || (elem == 3'd4);
        write_val      = (elem == 3'd1) || (elem == 3'd3);
        cycle_is_read  = run && elem_has_read && (phase == PH_READ);
        cycle_is_write = run && (!elem_has_read || (phase == PH_WRITE));
        last_addr      = elem_down ? (addr == '0) : (addr == ADDR_MAX);
        next_elem      = elem + 3'd1;
        next_down      = (next_elem == 3'd3) || (next_elem == 3'd4);
        miscompare     = chk_v && (sram_dout != chk_exp);
    end

    always_comb begin
        sram_we_n = ~cycle_is_write;
        sram_addr = run ? addr : '0;
        sram_din  = cycle_is_write ? write_val : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            elem        <= 3'd0;
            addr        <= '0;
            phase       <= PH_READ;
            chk_v       <= 1'b0;
            chk_exp     <= 1'b0;
            chk_addr    <= '0;
            chk_elem    <= 3'd0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_exp_q  <= 1'b0;
        end else begin
            chk_v <= cycle_is_read;
            if (cycle_is_read) begin
                chk_exp  <= read_exp;
                chk_addr <= addr;
                chk_elem <= elem;
            end

            if (miscompare) begin
                if (err_q == '0) begin
                    fail_addr_q <= chk_addr;
                    fail_elem_q <= chk_elem;
                    fail_exp_q  <= chk_exp;
                end
                if (err_q != CNT_MAX) begin
                    err_q <= err_q + CNT_ONE;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        elem        <= 3'd0;
                        addr        <= '0;
                        phase       <= PH_READ;
                        err_q       <= '0;
                        fail_addr_q <= '0;
                        fail_elem_q <= 3'd0;
                        fail_exp_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cycle_is_read && elem_has_write) begin
                        phase <= PH_WRITE;
                    end else begin
                        phase <= PH_READ;
                        if (last_addr) begin
                            if (elem == 3'd5) begin
                                state <= S_DRAIN;
                            end else begin
                                elem <= next_elem;
                                addr <= next_down ? ADDR_MAX : '0;
                            end
                        end else begin
                            addr <= elem_down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state == S_RUN) || (state == S_DRAIN);
        done      = (state == S_DONE);
        pass      = done && (err_q == '0);
        err_count = err_q;
        fail_addr = fail_addr_q;
        fail_elem = fail_elem_q;
        fail_exp  = fail_exp_q;
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - randomized fault-injection bench for sram_march_bist
module tb_sram_march_bist;

    localparam int ADDR_W = 7;
    localparam int CNT_W  = 8;
    localparam int N      = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic              fail_exp;
    logic              sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_din;
    logic              sram_dout;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic              we_n;
        logic [ADDR_W-1:0] addr;
        logic              din;
    } op_t;

    op_t exp_ops[$];
    op_t got_ops[$];

    logic [N-1:0] mem;
    logic [N-1:0] stuck_mask = '0;
    logic [N-1:0] stuck_val = '0;

    always #5 clk = ~clk;

    sram_march_bist #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .fail_exp(fail_exp),
        .sram_we_n(sram_we_n), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Array model with registered read and optional stuck-at cells
    always @(posedge clk) begin
        if (!rst_n) begin
            mem       <= '0;
            sram_dout <= 1'b0;
        end else begin
            if (!sram_we_n) mem[sram_addr] <= sram_din;
            sram_dout <= stuck_mask[sram_addr] ? stuck_val[sram_addr] : mem[sram_addr];
        end
    end

    task automatic model_run(output int e_cnt, output int f_addr, output int f_elem, output int f_exp);
        logic [N-1:0] m;
        int a;
        logic v;
        bit rd, wr, dn, rexp, wval;
        op_t o;
        m = '0;
        e_cnt = 0; f_addr = 0; f_elem = 0; f_exp = 0;
        exp_ops.delete();
        for (int e = 0; e < 6; e++) begin
            rd = (e != 0); wr = (e != 5); dn = (e == 3 || e == 4);
            rexp = (e == 2 || e == 4); wval = (e == 1 || e == 3);
            for (int i = 0; i < N; i++) begin
                a = dn ? N - 1 - i : i;
                if (rd) begin
                    o.we_n = 1'b1; o.addr = ADDR_W'(a); o.din = 1'b0;
                    exp_ops.push_back(o);
                    v = stuck_mask[a] ? stuck_val[a] : m[a];
                    if (v !== rexp) begin
                        if (e_cnt == 0) begin f_addr = a; f_elem = e; f_exp = int'(rexp); end
                        e_cnt++;
                    end
                end
                if (wr) begin
                    o.we_n = 1'b0; o.addr = ADDR_W'(a); o.din = wval;
                    exp_ops.push_back(o);
                    m[a] = wval;
                end
            end
        end
        if (e_cnt > 255) e_cnt = 255;
    endtask

    task automatic run_march(input string name, input int extra_start_cyc);
        int e_cnt, f_addr, f_elem, f_exp;
        int cyc, done_cyc, mism, first_bad;
        op_t o;
        model_run(e_cnt, f_addr, f_elem, f_exp);
        got_ops.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                tests_run++;
                if (busy !== 1'b1 || done !== 1'b0 || err_count !== '0 || fail_addr !== '0 ||
                    fail_elem !== 3'd0 || fail_exp !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s start_clear: busy=%b done=%b err=%0d faddr=%0d felem=%0d fexp=%b want busy=1 done=0 rest 0",
                             name, busy, done, err_count, fail_addr, fail_elem, fail_exp);
                end
            end
            if (cyc == extra_start_cyc) start = 1'b1;
            else if (cyc == extra_start_cyc + 1) start = 1'b0;
            if (cyc <= 10 * N) begin
                o.we_n = sram_we_n; o.addr = sram_addr; o.din = sram_din;
                got_ops.push_back(o);
            end
            if (cyc == 10 * N + 1) begin
                tests_run++;
                if (sram_we_n !== 1'b1 || sram_addr !== '0 || sram_din !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s drain: we_n=%b addr=%0d din=%b busy=%b done=%b want 1/0/0/1/0",
                             name, sram_we_n, sram_addr, sram_din, busy, done);
                end
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        start = 1'b0;

        tests_run++;
        if (done_cyc != 10 * N + 2) begin
            tests_failed++;
            $display("FAIL %s latency: done at cycle %0d (-1 = timeout) want %0d", name, done_cyc, 10 * N + 2);
        end

        mism = 0; first_bad = -1;
        for (int i = 0; i < exp_ops.size(); i++) begin
            if (i >= got_ops.size() || got_ops[i] !== exp_ops[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        tests_run++;
        if (mism != 0 || got_ops.size() != exp_ops.size()) begin
            tests_failed++;
            if (first_bad >= 0 && first_bad < got_ops.size())
                $display("FAIL %s trace: %0d bad ops, first at cycle %0d got we_n=%b addr=%0d din=%b want we_n=%b addr=%0d din=%b",
                         name, mism, first_bad + 1, got_ops[first_bad].we_n, got_ops[first_bad].addr,
                         got_ops[first_bad].din, exp_ops[first_bad].we_n, exp_ops[first_bad].addr, exp_ops[first_bad].din);
            else
                $display("FAIL %s trace: got %0d ops want %0d", name, got_ops.size(), exp_ops.size());
        end

        tests_run++;
        if (err_count !== CNT_W'(e_cnt) || pass !== (e_cnt == 0) || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s result: err=%0d pass=%b busy=%b want err=%0d pass=%0d busy=0",
                     name, err_count, pass, busy, e_cnt, (e_cnt == 0));
        end

        tests_run++;
        if (fail_addr !== ADDR_W'(f_addr) || fail_elem !== 3'(f_elem) || fail_exp !== 1'(f_exp)) begin
            tests_failed++;
            $display("FAIL %s first_fail: addr=%0d elem=%0d exp=%b want addr=%0d elem=%0d exp=%0d",
                     name, fail_addr, fail_elem, fail_exp, f_addr, f_elem, f_exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== '0 || fail_addr !== '0 ||
            fail_elem !== 3'd0 || fail_exp !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== '0 || sram_din !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s reset_outputs: busy=%b done=%b pass=%b err=%0d fa=%0d fe=%0d fx=%b we_n=%b addr=%0d din=%b want all 0 except we_n=1",
                     name, busy, done, pass, err_count, fail_addr, fail_elem, fail_exp, sram_we_n, sram_addr, sram_din);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("reset");
    endtask

    task automatic test_fault_free();
        stuck_mask = '0; stuck_val = '0;
        run_march("fault_free", -1);
    endtask

    task automatic test_stuck1_2a();
        stuck_mask = '0; stuck_val = '0;
        stuck_mask[8'h2A] = 1'b1; stuck_val[8'h2A] = 1'b1;
        run_march("stuck1_2a", -1);
        tests_run++;
        if (pass !== 1'b0 || err_count !== 8'd3 || fail_addr !== 7'h2A || fail_elem !== 3'd1 || fail_exp !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck1_2a spot: pass=%b err=%0d fa=%h fe=%0d fx=%b want 0/3/2a/1/0",
                     pass, err_count, fail_addr, fail_elem, fail_exp);
        end
    endtask

    task automatic test_rerun_clears();
        stuck_mask = '0; stuck_val = '0;
        run_march("rerun_clears", -1);
    endtask

    task automatic test_stuck0_05();
        stuck_mask = '0; stuck_val = '0;
        stuck_mask[5] = 1'b1; stuck_val[5] = 1'b0;
        run_march("stuck0_05", -1);
        tests_run++;
        if (pass !== 1'b0 || err_count !== 8'd2 || fail_addr !== 7'h05 || fail_elem !== 3'd2 || fail_exp !== 1'b1) begin
            tests_failed++;
            $display("FAIL stuck0_05 spot: pass=%b err=%0d fa=%h fe=%0d fx=%b want 0/2/05/2/1",
                     pass, err_count, fail_addr, fail_elem, fail_exp);
        end
    endtask

    task automatic test_start_while_busy();
        stuck_mask = '0; stuck_val = '0;
        run_march("start_while_busy", 500);
    endtask

    task automatic test_saturation();
        stuck_mask = '1; stuck_val = '1;
        run_march("saturation", -1);
    endtask

    task automatic test_random_faults();
        int nf, a;
        for (int t = 0; t < 4; t++) begin
            stuck_mask = '0; stuck_val = '0;
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) begin
                a = $urandom_range(0, N - 1);
                stuck_mask[a] = 1'b1;
                stuck_val[a] = 1'($urandom_range(0, 1));
            end
            run_march($sformatf("random%0d", t), (t == 2) ? $urandom_range(2, 1200) : -1);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        stuck_mask = '0; stuck_val = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 700) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("reset_mid_run");
        run_march("after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck1_2a();
        test_rerun_clears();
        test_stuck0_05();
        test_start_while_busy();
        test_saturation();
        test_random_faults();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
